// File: rtl/pc_pkg.sv
// Shared definitions for the Zepto fetch-stage PC sequencer:
// operation encodings and the return-stack pointer width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_OP_INC    = 3'd0,
    PC_OP_HOLD   = 3'd1,
    PC_OP_JUMP   = 3'd2,
    PC_OP_BRANCH = 3'd3,
    PC_OP_CALL   = 3'd4,
    PC_OP_RET    = 3'd5
  } pc_op_e;

  // One extra bit so the pointer can represent a completely full stack.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the PC sequencer; push and pop are mutually exclusive.
// empty_o/full_o are registered copies derived from the next pointer value.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = ptrWidth(STACK_DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    topIdx;
  logic             empty_q, full_q;
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];

  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_q) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop_i && !empty_q) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      ptr_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      empty_q <= (ptr_d == '0);
      full_q  <= (ptr_d == PW'(STACK_DEPTH));
    end
  end

  // Entry storage has no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (Reset && push_i && !full_q) begin
      mem_q[ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign topIdx  = ptr_q[AW-1:0] - AW'(1);
  assign top_o   = mem_q[topIdx];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, hold, jump, relative branch and
// call/return through an internal return-address stack, with sticky error flags.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               STACK_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter logic [WIDTH-1:0] INC_STEP    = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_ovf,
  output logic             stack_unf
);

  logic [WIDTH-1:0] pc_q, pc_d, pcInc, stackTop;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, stackEmpty, stackFull;

  assign pcInc = pc_q + INC_STEP;

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (en) begin
      case (pc_op_e'(op))
        PC_OP_HOLD:   pc_d = pc_q;
        PC_OP_JUMP:   pc_d = target;
        PC_OP_BRANCH: pc_d = pc_q + offset;
        PC_OP_CALL: begin
          if (!stackFull) begin
            push = 1'b1;
            pc_d = target;
          end else begin
            pc_d  = pcInc;
            ovf_d = 1'b1;
          end
        end
        PC_OP_RET: begin
          if (!stackEmpty) begin
            pop  = 1'b1;
            pc_d = stackTop;
          end else begin
            pc_d  = pcInc;
            unf_d = 1'b1;
          end
        end
        default:      pc_d = pcInc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ret_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .Reset   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pcInc),
    .top_o   (stackTop),
    .empty_o (stackEmpty),
    .full_o  (stackFull)
  );

  assign pc          = pc_q;
  assign stack_empty = stackEmpty;
  assign stack_full  = stackFull;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule
